vec_cmd_issuer: RTL
===================

Name: vec_cmd_issuer

Overview:
- Synthesizable command initiator that drives the vector accelerator top's request interface from a stream of host commands.
- Accepts one command at a time (valid/ready), issues it to the accelerator (v/ready) and waits for done.
- For read commands, captures the returned vector (v/yumi) and presents it on a result port until the consumer yumis.
- Sits between the host or instruction fetch and the vector top; replaces testbench-driven sequencing.

Parameters:
els_p, 10, number of vectors stored in the accelerator register file
vlen_p, 4, elements per vector
vdw_p, 4, bits per element
Derived: addr_w_lp = `BSG_SAFE_CLOG2(els_p); vec_w_lp = vlen_p*vdw_p

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous active-high reset
cmd_op_i  in  4  opcode: 1001 write, 1000 read, 00xx vector ALU, 01xx scalar ALU, 1111 dot product
cmd_addrA_i / cmd_addrB_i / cmd_addrD_i  in  addr_w_lp each  source A, source B, destination
cmd_scalar_i  in  vdw_p  scalar operand
cmd_wdata_i  in  vec_w_lp  write data
cmd_v_i  in  1  command valid
cmd_ready_o  out  1  command accepted when cmd_v_i & cmd_ready_o
acc_op_o, acc_addrA_o, acc_addrB_o, acc_addrD_o, acc_scalar_o, acc_wdata_o  out  as cmd_*  registered command to accelerator
acc_v_o  out  1  request valid
acc_ready_i  in  1  accelerator accepts request
acc_done_i  in  1  accelerator operation complete
acc_r_data_i  in  vec_w_lp  accelerator read data
acc_v_i  in  1  accelerator read data valid
acc_yumi_o  out  1  read data consumed
res_data_o  out  vec_w_lp  captured read vector
res_v_o  out  1  result valid
res_yumi_i  in  1  consumer takes result
busy_o  out  1  state != IDLE
retired_o  out  16  count of completed commands, wraps at 2^16

Behaviour:
- Reset (asynchronous assert, any cycle, including mid-operation):
  - State goes to IDLE.
  - acc_v_o, acc_yumi_o, res_v_o, busy_o = 0; retired_o = 0; all command registers and res_data_o = 0.
  - Any in-flight command and any pending result are dropped.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - cmd_ready_o = 1.
  - On cmd_v_i, latch all cmd_* fields into the acc_* registers and go to ISSUE.
  - acc_v_o rises the cycle after acceptance (1-cycle latency).
- ISSUE:
  - acc_v_o = 1; acc_* fields held stable.
  - On acc_ready_i, go to WAIT. acc_v_o is low from the next cycle.
- WAIT, non-read ops:
  - On acc_done_i, increment retired_o and go to IDLE.
- WAIT, read op (1000):
  - acc_yumi_o = acc_v_i while data is not yet captured.
  - On acc_v_i, capture acc_r_data_i into res_data_o and set an internal captured flag.
  - Also track whether acc_done_i has been seen; capture and done may occur in the same or different cycles, in either order.
  - When both captured and done are set, go to RESP.
- RESP:
  - res_v_o = 1 and res_data_o held stable.
  - On res_yumi_i, increment retired_o and go to IDLE.
  - res_yumi_i without res_v_o is ignored.
- acc_done_i or acc_v_i outside WAIT: ignored; acc_yumi_o stays 0.
- acc_done_i in the same cycle as acc_ready_i while in ISSUE: ignored. Done is only sampled in WAIT.
- cmd_ready_o = 0 in every state except IDLE. New commands are never buffered.
- Opcodes are forwarded unchanged. Reserved opcodes are issued like ALU ops and retire on done.
- retired_o wraps from 16'hFFFF to 0 with no flag.
- Minimum command turnaround is 4 cycles for non-read ops: accept, issue, done, IDLE.

Test Plan:
- Write then read:
  - Write addrD=1, wdata=16'h4321 -> acc_op_o=1001 and acc_v_o high 1 cycle after accept; retired_o=1 after done.
  - Read addrA=1 -> res_v_o with res_data_o=16'h4321; retired_o=2 after res_yumi_i.
- Vector add:
  - Preload R1=16'h0101, R2=16'h1144; issue op 0000 with A=1, B=2, D=0; then read 0 -> res_data_o=16'h1245.
- Backpressure:
  - acc_ready_i held low 5 cycles -> acc_v_o stays high and acc_addr*/op stay stable throughout; cmd_ready_o=0 throughout.
- Read ordering:
  - Case (a): acc_done_i 2 cycles before acc_v_i.
  - Case (b): acc_done_i and acc_v_i in the same cycle.
  - Both cases -> exactly one acc_yumi_o pulse, data captured once, RESP entered.
- Result hold:
  - res_yumi_i withheld 10 cycles -> res_v_o and res_data_o stable; cmd_ready_o=0; new cmd_v_i not accepted.
- Reset mid-WAIT on a read:
  - Assert reset_i asynchronously -> outputs cleared immediately, retired_o=0, no res_v_o afterward.
  - The next command is accepted normally.

Source files
------------

// File: rtl/vec_cmd_issuer.sv
// vec_cmd_issuer
//   Takes one host command at a time and sequences it onto the vector
//   accelerator's request interface. It holds the command until the
//   accelerator accepts it and then waits for done. For a read, it also
//   captures the returned vector and holds it on the result port until the
//   consumer takes it.
//
// Ports
//   clk_i, reset_i            clock, asynchronous active-high reset
//   cmd_*_i, cmd_v_i          host command fields and valid
//   cmd_ready_o               high only in IDLE; commands are never buffered
//   acc_*_o, acc_v_o          registered command to the accelerator, with valid
//   acc_ready_i, acc_done_i   accelerator accept / operation complete
//   acc_r_data_i, acc_v_i     accelerator read data and its valid
//   acc_yumi_o                read data consumed (at most once per read)
//   res_data_o, res_v_o       captured read vector and its valid
//   res_yumi_i                consumer takes the result
//   busy_o                    high whenever a command is in flight
//   retired_o                 completed-command count, wraps at 2^16
module vec_cmd_issuer #(
  parameter  int els_p     = 10,
  parameter  int vlen_p    = 4,
  parameter  int vdw_p     = 4,
  localparam int addr_w_lp = (els_p > 1) ? $clog2(els_p) : 1,
  localparam int vec_w_lp  = vlen_p * vdw_p
) (
  input  logic                 clk_i,
  input  logic                 reset_i,

  input  logic [3:0]           cmd_op_i,
  input  logic [addr_w_lp-1:0] cmd_addrA_i,
  input  logic [addr_w_lp-1:0] cmd_addrB_i,
  input  logic [addr_w_lp-1:0] cmd_addrD_i,
  input  logic [vdw_p-1:0]     cmd_scalar_i,
  input  logic [vec_w_lp-1:0]  cmd_wdata_i,
  input  logic                 cmd_v_i,
  output logic                 cmd_ready_o,

  output logic [3:0]           acc_op_o,
  output logic [addr_w_lp-1:0] acc_addrA_o,
  output logic [addr_w_lp-1:0] acc_addrB_o,
  output logic [addr_w_lp-1:0] acc_addrD_o,
  output logic [vdw_p-1:0]     acc_scalar_o,
  output logic [vec_w_lp-1:0]  acc_wdata_o,
  output logic                 acc_v_o,
  input  logic                 acc_ready_i,
  input  logic                 acc_done_i,
  input  logic [vec_w_lp-1:0]  acc_r_data_i,
  input  logic                 acc_v_i,
  output logic                 acc_yumi_o,

  output logic [vec_w_lp-1:0]  res_data_o,
  output logic                 res_v_o,
  input  logic                 res_yumi_i,

  output logic                 busy_o,
  output logic [15:0]          retired_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [3:0] OP_READ = 4'b1000;

  state_e                 state_q, state_n;

  logic [3:0]             op_q;
  logic [addr_w_lp-1:0]   addr_a_q, addr_b_q, addr_d_q;
  logic [vdw_p-1:0]       scalar_q;
  logic [vec_w_lp-1:0]    wdata_q;
  logic [vec_w_lp-1:0]    res_data_q;
  logic                   captured_q;
  logic                   done_seen_q;
  logic [15:0]            retired_q;

  logic                   is_read;
  logic                   accept;
  logic                   retire;

  assign is_read = (op_q == OP_READ);

  // State register.
  // NOTE: every flop is written with <= so all registers sample the same
  // pre-edge values; reset is in the sensitivity list, so it acts immediately.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_n;
  end

  // Next-state logic. For a read, capture and done can come in either order
  // or together, so this cycle's events are merged with the sticky flags.
  always_comb begin
    // NOTE: the default assignment first means every path assigns state_n,
    // so no latch is inferred.
    state_n = state_q;
    case (state_q)
      ST_IDLE:  if (cmd_v_i) state_n = ST_ISSUE;
      ST_ISSUE: if (acc_ready_i) state_n = ST_WAIT;
      ST_WAIT: begin
        if (is_read) begin
          if ((captured_q || acc_yumi_o) && (done_seen_q || acc_done_i))
            state_n = ST_RESP;
        end else if (acc_done_i) begin
          state_n = ST_IDLE;
        end
      end
      ST_RESP:  if (res_yumi_i) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Output and handshake decode.
  always_comb begin
    cmd_ready_o = (state_q == ST_IDLE);
    acc_v_o     = (state_q == ST_ISSUE);
    res_v_o     = (state_q == ST_RESP);
    busy_o      = (state_q != ST_IDLE);
    accept      = (state_q == ST_IDLE) && cmd_v_i;
    // Read data is consumed only once; after capture, acc_v_i is ignored.
    acc_yumi_o  = (state_q == ST_WAIT) && is_read && !captured_q && acc_v_i;
    retire      = ((state_q == ST_WAIT) && !is_read && acc_done_i) ||
                  ((state_q == ST_RESP) && res_yumi_i);
  end

  // Command, result and bookkeeping registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      op_q        <= '0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      addr_d_q    <= '0;
      scalar_q    <= '0;
      wdata_q     <= '0;
      res_data_q  <= '0;
      captured_q  <= 1'b0;
      done_seen_q <= 1'b0;
      retired_q   <= '0;
    end else begin
      if (accept) begin
        op_q        <= cmd_op_i;
        addr_a_q    <= cmd_addrA_i;
        addr_b_q    <= cmd_addrB_i;
        addr_d_q    <= cmd_addrD_i;
        scalar_q    <= cmd_scalar_i;
        wdata_q     <= cmd_wdata_i;
        captured_q  <= 1'b0;
        done_seen_q <= 1'b0;
      end
      if (acc_yumi_o) begin
        res_data_q <= acc_r_data_i;
        captured_q <= 1'b1;
      end
      // Done is only meaningful once the request has been accepted.
      if ((state_q == ST_WAIT) && is_read && acc_done_i)
        done_seen_q <= 1'b1;
      if (retire)
        retired_q <= retired_q + 16'd1;
    end
  end

  assign acc_op_o     = op_q;
  assign acc_addrA_o  = addr_a_q;
  assign acc_addrB_o  = addr_b_q;
  assign acc_addrD_o  = addr_d_q;
  assign acc_scalar_o = scalar_q;
  assign acc_wdata_o  = wdata_q;
  assign res_data_o   = res_data_q;
  assign retired_o    = retired_q;

endmodule
